network_interface: RTL and testbench

Local-port network interface between a processing element and its mesh switch. It packetizes core-side transmit requests into 48-bit flits with source ID and sequence number, and buffers them in a small FIFO. It drives the switch's local input, honouring the switch's busy back-pressure. In the receive direction it captures packets from the switch's local output into a one-entry buffer, presents them to the core with a valid/ready handshake, and back-pressures the switch with busy.

---
 rtl/network_interface_if.sv | 30 +++
 rtl/network_interface.sv | 106 ++++++++++
 tb/tb_network_interface.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/network_interface_if.sv
// Core- and switch-facing signals of the network interface, bundled so one port carries both directions.
// slave = the interface block itself, master = the core/switch environment that drives it.
interface network_interface_if #(
  parameter int PACKET_WIDTH = 48
);
  logic                    tx_valid;
  logic                    tx_ready;
  logic [3:0]              tx_dest;
  logic [31:0]             tx_data;
  logic [PACKET_WIDTH-1:0] pkt_out;
  logic                    busy_in;
  logic [PACKET_WIDTH-1:0] pkt_in;
  logic                    busy_out;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [3:0]              rx_src;
  logic [6:0]              rx_seq;
  logic [31:0]             rx_data;
  logic                    err_misroute;

  modport slave (
    input  tx_valid, tx_dest, tx_data, busy_in, pkt_in, rx_ready,
    output tx_ready, pkt_out, busy_out, rx_valid, rx_src, rx_seq, rx_data, err_misroute
  );

  modport master (
    output tx_valid, tx_dest, tx_data, busy_in, pkt_in, rx_ready,
    input  tx_ready, pkt_out, busy_out, rx_valid, rx_src, rx_seq, rx_data, err_misroute
  );
endinterface

// File: rtl/network_interface.sv
// Mesh local-port NI: packetizes core TX into a FIFO toward the switch (pops while busy_in low, one flit/cycle),
// and holds one received packet for the core behind a valid/ready handshake, back-pressuring the switch with busy_out.
module network_interface #(
  parameter int ID           = 0,
  parameter int PACKET_WIDTH = 48,
  parameter int DEPTH        = 4
) (
  input  logic               clk,
  input  logic               reset,
  network_interface_if.slave ni
);
  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = AW + 1;
  localparam logic [3:0]      NODE_ID  = 4'(ID);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [CW-1:0]           count_q;
  logic [CW-1:0]           count_d;
  logic [6:0]              seq_q;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  logic                    rx_full_q;
  logic [3:0]              rx_src_q;
  logic [6:0]              rx_seq_q;
  logic [31:0]             rx_data_q;
  logic                    err_q;
  logic                    capture;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = ni.tx_valid && ni.tx_ready;
  assign pop   = !empty && !ni.busy_in;

  assign ni.tx_ready = !full && !reset;
  // Head comes straight from storage, so tx_* never reaches pkt_out combinationally.
  assign ni.pkt_out  = (reset || empty) ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {1'b1, ni.tx_dest, NODE_ID, seq_q, ni.tx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      seq_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        seq_q    <= seq_q + 7'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // A valid flit arriving while full is a switch protocol violation and is dropped silently.
  assign capture = ni.pkt_in[PACKET_WIDTH-1] && !rx_full_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_full_q <= 1'b0;
      rx_src_q  <= '0;
      rx_seq_q  <= '0;
      rx_data_q <= '0;
      err_q     <= 1'b0;
    end else if (capture) begin
      rx_full_q <= 1'b1;
      rx_src_q  <= ni.pkt_in[42:39];
      rx_seq_q  <= ni.pkt_in[38:32];
      rx_data_q <= ni.pkt_in[31:0];
      if (ni.pkt_in[46:43] != NODE_ID) begin
        err_q <= 1'b1;
      end
    end else if (rx_full_q && ni.rx_ready) begin
      rx_full_q <= 1'b0;
    end
  end

  assign ni.busy_out     = rx_full_q || reset;
  assign ni.rx_valid     = rx_full_q && !reset;
  assign ni.rx_src       = rx_src_q;
  assign ni.rx_seq       = rx_seq_q;
  assign ni.rx_data      = rx_data_q;
  assign ni.err_misroute = err_q;
endmodule

// File: tb/tb_network_interface.sv
// Scoreboarded bench for network_interface at ID=5: stimulus queues expected flits/packets,
// negedge monitors pop and compare on every TX transfer and RX handshake.
module tb_network_interface;
  logic clk;
  logic reset;

  network_interface_if #(.PACKET_WIDTH(48)) nif ();

  network_interface #(.ID(5), .PACKET_WIDTH(48), .DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .ni    (nif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [47:0] exp_tx [$];
  logic [42:0] exp_rx [$];
  logic [6:0]  seq_m = 7'd0;
  logic [6:0]  seq_log [256];
  int          tx_idx = 0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && nif.pkt_out[47] && !nif.busy_in) begin
      if (exp_tx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected: got %h expected no flit", nif.pkt_out);
      end else begin
        chk("tx_flit", nif.pkt_out, exp_tx.pop_front());
        if (tx_idx < 256) seq_log[tx_idx] = nif.pkt_out[38:32];
        tx_idx++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && nif.rx_valid && nif.rx_ready) begin
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected no packet", {nif.rx_src, nif.rx_seq, nif.rx_data});
      end else begin
        chk("rx_pkt", {5'd0, nif.rx_src, nif.rx_seq, nif.rx_data}, {5'd0, exp_rx.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that takes the packet.
  task automatic push(input logic [3:0] d, input logic [31:0] data);
    int n;
    n = 0;
    nif.tx_valid = 1'b1;
    nif.tx_dest  = d;
    nif.tx_data  = data;
    @(negedge clk);
    while (!nif.tx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!nif.tx_ready) begin
      checks++;
      errors++;
      $display("FAIL tx_accept_timeout: got tx_ready 0 expected 1 within 20 cycles");
    end else begin
      exp_tx.push_back({1'b1, d, 4'd5, seq_m, data});
      seq_m++;
    end
    tick();
    nif.tx_valid = 1'b0;
  endtask

  task automatic inject(input logic [47:0] p);
    nif.pkt_in = p;
    tick();
    nif.pkt_in = 48'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_tx.delete();
    exp_rx.delete();
    seq_m  = 7'd0;
    tx_idx = 0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    nif.tx_valid = 1'b0;
    nif.tx_dest  = 4'h0;
    nif.tx_data  = 32'h0;
    nif.busy_in  = 1'b0;
    nif.pkt_in   = 48'h0;
    nif.rx_ready = 1'b0;

    // Reset held for two edges, then idle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_tx_ready", {47'd0, nif.tx_ready}, 48'd0);
      chk("rst_busy_out", {47'd0, nif.busy_out}, 48'd1);
      chk("rst_pkt_out", nif.pkt_out, 48'h0);
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    chk("idle_tx_ready", {47'd0, nif.tx_ready}, 48'd1);
    chk("idle_busy_out", {47'd0, nif.busy_out}, 48'd0);
    chk("idle_rx_valid", {47'd0, nif.rx_valid}, 48'd0);
    chk("idle_err", {47'd0, nif.err_misroute}, 48'd0);
    tick();

    // Single TX.
    push(4'h3, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_pkt_out", nif.pkt_out, 48'h9A80_DEADBEEF);
    tick();
    @(negedge clk);
    chk("single_after_pop", nif.pkt_out, 48'h0);
    tick();

    // Back-pressure until full, then drain.
    do_reset();
    nif.busy_in = 1'b1;
    for (int i = 0; i < 4; i++) push(4'h0, 32'hA0 + i);
    @(negedge clk);
    chk("full_tx_ready", {47'd0, nif.tx_ready}, 48'd0);
    chk("full_head_held", nif.pkt_out, 48'h8280_000000A0);
    tick();
    nif.busy_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_seq", {41'd0, nif.pkt_out[38:32]}, 48'(i));
      if (i == 0) chk("drain_ready_before_pop", {47'd0, nif.tx_ready}, 48'd0);
      if (i == 1) chk("drain_ready_after_pop", {47'd0, nif.tx_ready}, 48'd1);
      tick();
    end
    @(negedge clk);
    chk("drain_empty", nif.pkt_out, 48'h0);
    tick();

    // Sequence wrap with back-to-back pushes.
    do_reset();
    for (int i = 0; i < 130; i++) push(4'h1, 32'h1000 + i);
    repeat (3) tick();
    chk("wrap_seq127", {41'd0, seq_log[127]}, 48'd127);
    chk("wrap_seq128", {41'd0, seq_log[128]}, 48'd0);
    chk("wrap_seq129", {41'd0, seq_log[129]}, 48'd1);

    // RX handshake and ignored second packet.
    do_reset();
    exp_rx.push_back({4'd2, 7'd9, 32'h12345678});
    inject({1'b1, 4'd5, 4'd2, 7'd9, 32'h12345678});
    @(negedge clk);
    chk("rx_valid", {47'd0, nif.rx_valid}, 48'd1);
    chk("rx_src", {44'd0, nif.rx_src}, 48'd2);
    chk("rx_seq", {41'd0, nif.rx_seq}, 48'd9);
    chk("rx_busy_out", {47'd0, nif.busy_out}, 48'd1);
    tick();
    inject({1'b1, 4'd7, 4'd3, 7'd10, 32'hCAFEF00D});
    @(negedge clk);
    chk("rx_ignore_src", {44'd0, nif.rx_src}, 48'd2);
    chk("rx_ignore_data", {16'd0, nif.rx_data}, 48'h12345678);
    chk("rx_ignore_no_err", {47'd0, nif.err_misroute}, 48'd0);
    tick();
    nif.rx_ready = 1'b1;
    tick();
    nif.rx_ready = 1'b0;
    @(negedge clk);
    chk("rx_consumed_valid", {47'd0, nif.rx_valid}, 48'd0);
    chk("rx_consumed_busy", {47'd0, nif.busy_out}, 48'd0);
    tick();

    // Misroute, then reset with TX entries queued.
    exp_rx.push_back({4'd4, 7'd3, 32'hCAFE0001});
    inject({1'b1, 4'd7, 4'd4, 7'd3, 32'hCAFE0001});
    @(negedge clk);
    chk("misroute_err", {47'd0, nif.err_misroute}, 48'd1);
    chk("misroute_delivered", {47'd0, nif.rx_valid}, 48'd1);
    tick();
    nif.rx_ready = 1'b1;
    tick();
    nif.rx_ready = 1'b0;
    @(negedge clk);
    chk("misroute_sticky", {47'd0, nif.err_misroute}, 48'd1);
    tick();
    nif.busy_in = 1'b1;
    for (int i = 0; i < 3; i++) push(4'h6, 32'hB0 + i);
    do_reset();
    @(negedge clk);
    chk("mid_rst_pkt_out", nif.pkt_out, 48'h0);
    chk("mid_rst_err", {47'd0, nif.err_misroute}, 48'd0);
    chk("mid_rst_rx_valid", {47'd0, nif.rx_valid}, 48'd0);
    tick();
    nif.busy_in = 1'b0;
    push(4'h2, 32'h55);
    @(negedge clk);
    chk("mid_rst_seq0", nif.pkt_out, 48'h9280_00000055);
    repeat (3) tick();
    chk("tx_drained", 48'(exp_tx.size()), 48'd0);
    chk("rx_drained", 48'(exp_rx.size()), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
